// File: rtl/keycode_event_decoder.sv
// Keycode event decoder.
// Compares each new 4-slot keycode snapshot against the last committed key set.
// It emits release events and then press events into a show-ahead event FIFO.
// Slot position is ignored: only membership of a code in the set matters.
// FIFO_DEPTH must be a power of two, 2 or larger.
module keycode_event_decoder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   keycode,
    input  logic                          ev_rd,
    input  logic                          clr_ovf,
    output logic [8:0]                    ev_data,
    output logic                          ev_valid,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          overflow,
    output logic                          busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        REL,
        PRS,
        COMMIT
    } state_t;

    state_t      state;
    logic [31:0] prev;     // last committed key set
    logic [31:0] snap;     // key set under scan
    logic [1:0]  idx;      // slot currently examined

    logic [7:0]  rel_code;
    logic [7:0]  prs_code;
    logic        rel_in_snap;
    logic        prs_in_prev;
    logic        prs_dup;
    logic        push;
    logic [8:0]  push_data;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          drop;

    // Event generation: decide whether the slot under scan produces an event this cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        push        = 1'b0;
        push_data   = '0;
        rel_in_snap = 1'b0;
        prs_in_prev = 1'b0;
        prs_dup     = 1'b0;
        rel_code    = prev[{idx, 3'b000} +: 8];
        prs_code    = snap[{idx, 3'b000} +: 8];
        for (int j = 0; j < 4; j++) begin
            if (snap[8*j +: 8] == rel_code) rel_in_snap = 1'b1;
            if (prev[8*j +: 8] == prs_code) prs_in_prev = 1'b1;
            // An earlier slot of the same snapshot holding this code already reported it.
            if ((j < int'(idx)) && (snap[8*j +: 8] == prs_code)) prs_dup = 1'b1;
        end
        case (state)
            REL: begin
                if ((rel_code != 8'h00) && !rel_in_snap) begin
                    push      = 1'b1;
                    push_data = {1'b0, rel_code};
                end
            end
            PRS: begin
                if ((prs_code != 8'h00) && !prs_in_prev && !prs_dup) begin
                    push      = 1'b1;
                    push_data = {1'b1, prs_code};
                end
            end
            default: ;
        endcase
    end

    // Scan sequencer: detect a change, walk the release slots and then the press slots, then commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            prev  <= '0;
            snap  <= '0;
            idx   <= '0;
            busy  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            case (state)
                IDLE: begin
                    if (keycode != prev) begin
                        snap  <= keycode;
                        idx   <= '0;
                        state <= REL;
                        busy  <= 1'b1;
                    end
                end
                REL: begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) state <= PRS;
                end
                PRS: begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) state <= COMMIT;
                end
                COMMIT: begin
                    prev  <= snap;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO control: pops need data present, and a push into a full FIFO only goes ahead alongside a pop.
    assign pop   = ev_rd && ev_valid;
    assign full  = (ev_count == CW'(FIFO_DEPTH));
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    // Event storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; the pointers and count alone define what is valid.
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    // FIFO pointers, occupancy and sticky overflow flag; a drop wins over clr_ovf.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ev_count <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   ev_count <= ev_count + 1'b1;
                2'b01:   ev_count <= ev_count - 1'b1;
                default: ev_count <= ev_count;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    assign ev_valid = (ev_count != '0);
    assign ev_data  = ev_valid ? mem[rd_ptr] : 9'h000;

endmodule

// File: tb/tb_keycode_event_decoder.sv
// Self-checking bench for keycode_event_decoder.
// The reference model tracks the committed key set and a scan phase counter.
// It derives each slot's event from set membership and keeps the expected FIFO contents in a queue.
module tb_keycode_event_decoder;

    localparam int DEPTH = 8;

    logic                      clk;
    logic                      reset;
    logic [31:0]               keycode;
    logic                      ev_rd;
    logic                      clr_ovf;
    logic [8:0]                ev_data;
    logic                      ev_valid;
    logic [$clog2(DEPTH):0]    ev_count;
    logic                      overflow;
    logic                      busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [31:0] m_prev;
    logic [31:0] m_snap;
    int          m_phase;  // 0 idle, 1..4 release slots, 5..8 press slots, 9 commit
    logic [8:0]  m_q[$];
    logic        m_ovf;

    keycode_event_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .keycode  (keycode),
        .ev_rd    (ev_rd),
        .clr_ovf  (clr_ovf),
        .ev_data  (ev_data),
        .ev_valid (ev_valid),
        .ev_count (ev_count),
        .overflow (overflow),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit in_slots(input logic [31:0] s, input logic [7:0] c, input int n);
        for (int i = 0; i < n; i++)
            if (s[8*i +: 8] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Event (if any) the design pushes on the coming edge, given the model's scan position.
    function automatic bit m_push_now(output logic [8:0] d);
        logic [7:0] c;
        int         s;
        d = 9'h000;
        if (m_phase >= 1 && m_phase <= 4) begin
            s = m_phase - 1;
            c = m_prev[8*s +: 8];
            if (c != 8'h00 && !in_slots(m_snap, c, 4)) begin
                d = {1'b0, c};
                return 1'b1;
            end
        end else if (m_phase >= 5 && m_phase <= 8) begin
            s = m_phase - 5;
            c = m_snap[8*s +: 8];
            if (c != 8'h00 && !in_slots(m_prev, c, 4) && !in_slots(m_snap, c, s)) begin
                d = {1'b1, c};
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_prev  = '0;
        m_snap  = '0;
        m_phase = 0;
        m_q.delete();
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge(input logic [31:0] kc, input logic rd, input logic clr);
        logic [8:0] d;
        bit         p;
        bit         dropped;
        p = m_push_now(d);
        dropped = 1'b0;
        if (rd && m_q.size() > 0) void'(m_q.pop_front());
        if (p) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else begin
                m_ovf   = 1'b1;
                dropped = 1'b1;
            end
        end
        if (clr && !dropped) m_ovf = 1'b0;
        if (m_phase == 0) begin
            if (kc != m_prev) begin
                m_snap  = kc;
                m_phase = 1;
            end
        end else if (m_phase == 9) begin
            m_prev  = m_snap;
            m_phase = 0;
        end else begin
            m_phase++;
        end
    endtask

    task automatic compare_all();
        logic [8:0] exp_data;
        exp_data = (m_q.size() != 0) ? m_q[0] : 9'h000;
        check("ev_valid", ev_valid, (m_q.size() != 0));
        check("ev_count", ev_count, m_q.size());
        check("ev_data",  ev_data,  exp_data);
        check("overflow", overflow, m_ovf);
        check("busy",     busy,     (m_phase != 0));
    endtask

    // One clock: drive inputs after a falling edge, step the model, compare at the next falling edge.
    task automatic cycle(input logic [31:0] kc, input logic rd, input logic clr);
        keycode = kc;
        ev_rd   = rd;
        clr_ovf = clr;
        model_edge(kc, rd, clr);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        keycode = '0;
        ev_rd   = 1'b0;
        clr_ovf = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_scan(input logic [31:0] kc, input logic rd);
        for (int i = 0; i < 12; i++) cycle(kc, rd, 1'b0);
    endtask

    function automatic logic [31:0] rand_keys();
        logic [31:0] k;
        for (int i = 0; i < 4; i++)
            k[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 6));
        return k;
    endfunction

    initial begin
        logic [8:0]  d;
        logic [8:0]  full_list[8];
        logic [31:0] kc;
        bit          p;
        bit          saw_push;
        int          busy_n;
        int          rd_pct;

        reset   = 1'b1;
        keycode = '0;
        ev_rd   = 1'b0;
        clr_ovf = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_ev_count", ev_count, 0);
        check("rst_ev_data",  ev_data,  0);
        check("rst_overflow", overflow, 0);
        check("rst_busy",     busy,     0);
        reset = 1'b0;

        // Single press after reset; busy spans the 9 cycles following the detect cycle.
        busy_n = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(32'h0000_0004, 1'b0, 1'b0);
            if (busy) busy_n++;
        end
        check("press_busy_cycles", busy_n, 9);
        check("press_count", ev_count, 1);
        check("press_event", ev_data, 9'h104);
        cycle(32'h0000_0004, 1'b1, 1'b0);

        // Adding 0x05, then replacing 0x04 with 0x07 while 0x05 moves slot.
        run_scan(32'h0000_0504, 1'b0);
        check("add_event", ev_data, 9'h105);
        cycle(32'h0000_0504, 1'b1, 1'b0);
        run_scan(32'h0000_0705, 1'b0);
        check("relprs_count", ev_count, 2);
        check("relprs_first", ev_data, 9'h004);
        cycle(32'h0000_0705, 1'b1, 1'b0);
        check("relprs_second", ev_data, 9'h107);
        cycle(32'h0000_0705, 1'b1, 1'b0);

        // Duplicate code in one snapshot, then the same key alone in another slot.
        do_reset();
        run_scan(32'h0404_0000, 1'b0);
        check("dup_count", ev_count, 1);
        check("dup_event", ev_data, 9'h104);
        busy_n = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(32'h0000_0004, 1'b0, 1'b0);
            if (busy) busy_n++;
        end
        check("move_scan_ran", busy_n, 9);
        check("move_no_events", ev_count, 1);

        // Overflow: 4 presses, then 4 releases fill the FIFO and the next 4 presses are dropped.
        do_reset();
        run_scan(32'h0403_0201, 1'b0);
        run_scan(32'h0807_0605, 1'b0);
        check("ovf_count", ev_count, 8);
        check("ovf_flag", overflow, 1);
        full_list = '{9'h101, 9'h102, 9'h103, 9'h104, 9'h001, 9'h002, 9'h003, 9'h004};
        for (int i = 0; i < 8; i++) begin
            check("ovf_contents", ev_data, full_list[i]);
            cycle(32'h0807_0605, 1'b1, 1'b0);
        end
        check("ovf_sticky", overflow, 1);
        cycle(32'h0807_0605, 1'b0, 1'b1);
        check("ovf_cleared", overflow, 0);

        // Full FIFO with a pop exactly on the push cycle: both happen, nothing dropped.
        do_reset();
        run_scan(32'h0403_0201, 1'b0);
        run_scan(32'h0000_0000, 1'b0);
        check("full_count", ev_count, 8);
        check("full_no_ovf", overflow, 0);
        saw_push = 1'b0;
        for (int i = 0; i < 12; i++) begin
            p = m_push_now(d);
            if (p) saw_push = 1'b1;
            cycle(32'h0000_0009, p, 1'b0);
        end
        check("pushpop_seen", saw_push, 1);
        check("pushpop_count", ev_count, 8);
        check("pushpop_no_ovf", overflow, 0);
        check("pushpop_head", ev_data, 9'h102);

        // Reset while pressing: queued events and the scan are discarded, then the held key rescans.
        do_reset();
        while (m_phase != 6) cycle(32'h0000_0004, 1'b0, 1'b0);
        check("midscan_queued", ev_valid, 1);
        reset = 1'b1;
        #1;
        model_reset();
        check("midscan_valid", ev_valid, 0);
        check("midscan_busy", busy, 0);
        check("midscan_count", ev_count, 0);
        @(negedge clk);
        reset = 1'b0;
        run_scan(32'h0000_0004, 1'b0);
        check("rescan_count", ev_count, 1);
        check("rescan_event", ev_data, 9'h104);

        // Randomized traffic with changing pop pressure and occasional overflow clears.
        do_reset();
        kc = '0;
        rd_pct = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) rd_pct = $urandom_range(0, 100);
            if ($urandom_range(0, 7) == 0) kc = rand_keys();
            cycle(kc, ($urandom_range(0, 99) < rd_pct), ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
